slow_frame_receiver: RTL

SLOW_FRAME_RECEIVER -- requirements
Module: slow_frame_receiver

---
 rtl/slow_frame_receiver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/slow_frame_receiver.sv
// rtl/slow_frame_receiver.sv - comma-delimited, XOR-checked frame receiver for a slow 8b/10b word stream
//
// Ports:
//   clk            system clock, single domain
//   reset          asynchronous active-low reset
//   word_tick_i    one-cycle strobe, decoded word valid on data_i/comma_i/error_i
//   data_i         decoded byte
//   comma_i        word is a comma (frame start)
//   error_i        code/disparity error on this word
//   payload_o      last good payload, byte 0 in [7:0]
//   frame_tick_o   one-cycle pulse, new good payload on payload_o
//   frame_error_o  one-cycle pulse, frame discarded
//   locked_o       high after a good frame, low after any discarded frame
//   good_count_o   good-frame counter, wraps
//   bad_count_o    discarded-frame counter, saturates
module slow_frame_receiver #(
    parameter int NUM_BYTES    = 16,
    parameter int WORD_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   word_tick_i,
    input  logic [7:0]             data_i,
    input  logic                   comma_i,
    input  logic                   error_i,
    output logic [8*NUM_BYTES-1:0] payload_o,
    output logic                   frame_tick_o,
    output logic                   frame_error_o,
    output logic                   locked_o,
    output logic [15:0]            good_count_o,
    output logic [15:0]            bad_count_o
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMO_W = $clog2(WORD_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    // The word gap is over-long when the counter would step onto WORD_TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WORD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             xor_q, xor_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
    logic [8*NUM_BYTES-1:0] payload_q, payload_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   frame_error_q, frame_error_d;
    logic                   locked_q, locked_d;
    logic [15:0]            good_q, good_d;
    logic [15:0]            bad_q, bad_d;
    logic                   good_frame, bad_frame;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        tmo_d      = tmo_q;
        shadow_d   = shadow_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;

        case (state_q)
            HUNT: begin
                tmo_d = '0;
                // A comma flagged with error_i counts as an error, which HUNT ignores.
                if (word_tick_i && comma_i && !error_i) begin
                    state_d = RECEIVE;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            RECEIVE, CHECK: begin
                if (word_tick_i) begin
                    tmo_d = '0;
                    if (error_i) begin
                        bad_frame = 1'b1;
                        state_d   = HUNT;
                    end else if (comma_i) begin
                        // Resync: this comma starts the next frame directly.
                        bad_frame = 1'b1;
                        state_d   = RECEIVE;
                        idx_d     = '0;
                        xor_d     = '0;
                    end else if (state_q == RECEIVE) begin
                        for (int i = 0; i < NUM_BYTES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                shadow_d[8*i +: 8] = data_i;
                            end
                        end
                        xor_d = xor_q ^ data_i;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = CHECK;
                        end
                    end else begin
                        if (data_i == xor_q) begin
                            good_frame = 1'b1;
                        end else begin
                            bad_frame = 1'b1;
                        end
                        state_d = HUNT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    bad_frame = 1'b1;
                    state_d   = HUNT;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_comb begin
        payload_d     = payload_q;
        good_d        = good_q;
        bad_d         = bad_q;
        locked_d      = locked_q;
        frame_tick_d  = good_frame;
        frame_error_d = bad_frame;
        if (good_frame) begin
            payload_d = shadow_q;
            good_d    = good_q + 16'd1;
            locked_d  = 1'b1;
        end
        if (bad_frame) begin
            if (bad_q != 16'hFFFF) begin
                bad_d = bad_q + 16'd1;
            end
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            idx_q         <= '0;
            xor_q         <= '0;
            tmo_q         <= '0;
            shadow_q      <= '0;
            payload_q     <= '0;
            frame_tick_q  <= 1'b0;
            frame_error_q <= 1'b0;
            locked_q      <= 1'b0;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            tmo_q         <= tmo_d;
            shadow_q      <= shadow_d;
            payload_q     <= payload_d;
            frame_tick_q  <= frame_tick_d;
            frame_error_q <= frame_error_d;
            locked_q      <= locked_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
        end
    end

    assign payload_o     = payload_q;
    assign frame_tick_o  = frame_tick_q;
    assign frame_error_o = frame_error_q;
    assign locked_o      = locked_q;
    assign good_count_o  = good_q;
    assign bad_count_o   = bad_q;

endmodule
